// File: rtl/serv_ibus_prefetch_if.sv
// Core fetch port plus Wishbone instruction-memory port seen by serv_ibus_prefetch.
// Signal directions are named from the prefetcher's side; the slave modport is the prefetcher.
`timescale 1ns/1ps
interface serv_ibus_prefetch_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] o_wb_adr;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack, o_wb_adr, o_wb_cyc
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack, o_wb_adr, o_wb_cyc
  );
endinterface

// File: rtl/serv_ibus_prefetch.sv
// Single-entry sequential instruction prefetch buffer; hit acks 1 cycle after request, miss acks 1 cycle after i_wb_ack.
// Next-word prefetch is built only with SERV_IBUS_PREFETCH_EN defined; otherwise the buffer just keeps the last demand word.
`timescale 1ns/1ps
module serv_ibus_prefetch (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  serv_ibus_prefetch_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH, ACK} state_t;

  state_t      state_q, state_d;
  logic        buf_vld_q, buf_vld_d;
  logic [29:0] buf_adr_q, buf_adr_d;
  logic [31:0] buf_dat_q, buf_dat_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        ack_q, ack_d;
  logic [31:0] rdt_q, rdt_d;
`ifdef SERV_IBUS_PREFETCH_EN
  logic [29:0] pf_adr_q, pf_adr_d;
  logic        stale_q, stale_d;
`endif

  logic [29:0] req_adr;
  logic        hit;
  logic [1:0]  unused_adr_bits;

  assign req_adr         = bus.i_ibus_adr[31:2];
  assign unused_adr_bits = bus.i_ibus_adr[1:0];
  assign hit             = buf_vld_q && !i_flush && (buf_adr_q == req_adr);

  always_comb begin
    state_d   = state_q;
    buf_vld_d = buf_vld_q;
    buf_adr_d = buf_adr_q;
    buf_dat_d = buf_dat_q;
    wb_adr_d  = wb_adr_q;
    wb_cyc_d  = wb_cyc_q;
    ack_d     = 1'b0;
    rdt_d     = rdt_q;
`ifdef SERV_IBUS_PREFETCH_EN
    pf_adr_d  = pf_adr_q;
    stale_d   = stale_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.i_ibus_cyc) begin
          if (hit) begin
            state_d  = ACK;
            ack_d    = 1'b1;
            rdt_d    = buf_dat_q;
`ifdef SERV_IBUS_PREFETCH_EN
            pf_adr_d = req_adr + 30'd1;
`endif
          end else begin
            state_d  = DEMAND;
            wb_cyc_d = 1'b1;
            wb_adr_d = {req_adr, 2'b00};
          end
        end
      end

      DEMAND: begin
        // Entered with wb_cyc low after a prefetch so the bus sees an idle cycle between cycles.
        if (!wb_cyc_q) begin
          wb_cyc_d = 1'b1;
        end else if (bus.i_wb_ack) begin
          wb_cyc_d  = 1'b0;
          buf_dat_d = bus.i_wb_rdt;
          buf_adr_d = wb_adr_q[31:2];
          buf_vld_d = 1'b1;
          state_d   = ACK;
          ack_d     = 1'b1;
          rdt_d     = bus.i_wb_rdt;
`ifdef SERV_IBUS_PREFETCH_EN
          pf_adr_d  = wb_adr_q[31:2] + 30'd1;
`endif
        end
      end

      ACK: begin
`ifdef SERV_IBUS_PREFETCH_EN
        state_d  = PREFETCH;
        wb_cyc_d = 1'b1;
        wb_adr_d = {pf_adr_q, 2'b00};
        stale_d  = 1'b0;
`else
        state_d  = IDLE;
`endif
      end

`ifdef SERV_IBUS_PREFETCH_EN
      PREFETCH: begin
        if (bus.i_wb_ack) begin
          wb_cyc_d = 1'b0;
          stale_d  = 1'b0;
          if (!stale_q && !i_flush) begin
            buf_dat_d = bus.i_wb_rdt;
            buf_adr_d = pf_adr_q;
            buf_vld_d = 1'b1;
          end
          if (bus.i_ibus_cyc && req_adr == pf_adr_q && !stale_q && !i_flush) begin
            state_d  = ACK;
            ack_d    = 1'b1;
            rdt_d    = bus.i_wb_rdt;
            pf_adr_d = pf_adr_q + 30'd1;
          end else if (bus.i_ibus_cyc) begin
            state_d  = DEMAND;
            wb_adr_d = {req_adr, 2'b00};
          end else begin
            state_d  = IDLE;
          end
        end else if (i_flush) begin
          stale_d = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    if (i_flush) buf_vld_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      buf_vld_q <= 1'b0;
      buf_adr_q <= '0;
      buf_dat_q <= '0;
      wb_adr_q  <= '0;
      wb_cyc_q  <= 1'b0;
      ack_q     <= 1'b0;
      rdt_q     <= '0;
`ifdef SERV_IBUS_PREFETCH_EN
      pf_adr_q  <= '0;
      stale_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      buf_vld_q <= buf_vld_d;
      buf_adr_q <= buf_adr_d;
      buf_dat_q <= buf_dat_d;
      wb_adr_q  <= wb_adr_d;
      wb_cyc_q  <= wb_cyc_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
`ifdef SERV_IBUS_PREFETCH_EN
      pf_adr_q  <= pf_adr_d;
      stale_q   <= stale_d;
`endif
    end
  end

  assign bus.o_ibus_ack = ack_q;
  assign bus.o_ibus_rdt = rdt_q;
  assign bus.o_wb_adr   = wb_adr_q;
  assign bus.o_wb_cyc   = wb_cyc_q;

endmodule
